pipe_ctrl_gen: RTL and testbench
================================

Name: pipe_ctrl_gen

Overview:
- Parametrised pipeline controller for the MIPS core, the next generation of the stall/flush/redirect controller.
- Generalises the stage count and address width.
- Makes the exception vector base relocatable.
- Registers the flush/redirect and holds it for a configurable number of cycles via a small FSM.
- Adds a stall watchdog.
- Sits beside the pipeline: takes per-stage stall requests plus the MEM-stage exception code and CP0 EPC; drives per-stage stall enables, flush and redirect PC.

Parameters:
- NSTAGE, 6, number of stall-controlled positions; bit 0 = PC, bit 1 = IF, … bit NSTAGE-1 = WB.
- AW, 32, PC/address width.
- FLUSH_CYCLES, 1, cycles flush_o stays high per exception (≥1).
- STALL_TIMEOUT, 1024, consecutive stalled cycles before the watchdog pulse; 0 disables the watchdog.
- VEC_INT_OFF, 32'h20, interrupt vector offset from ebase_i.
- VEC_GEN_OFF, 32'h40, general exception vector offset from ebase_i.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- excepttype_i  in  32  exception code from MEM stage; 0 = none
- cp0_epc_i  in  AW  EPC, used for eret
- ebase_i  in  AW  exception vector base
- stall_req_i  in  NSTAGE  per-stage stall request, bit k from stage k
- stall_o  out  NSTAGE  stage hold enables
- flush_o  out  1  pipeline flush
- new_pc_o  out  AW  redirect target, valid while flush_o=1
- busy_o  out  1  FSM in FLUSH
- stall_timeout_o  out  1  one-cycle watchdog pulse
- exc_code_o  out  5  low 5 bits of the last accepted exception code

Behaviour:
- Reset: all outputs 0; FSM = IDLE; watchdog counter = 0.
- FSM states:
  - IDLE→FLUSH when excepttype_i≠0 in IDLE.
  - FLUSH→IDLE after FLUSH_CYCLES cycles in FLUSH.
  - Flush cycle counter width = $clog2(FLUSH_CYCLES+1).
- Exception accept (cycle t, in IDLE, excepttype_i≠0):
  - At edge t→t+1, register flush_o=1, busy_o=1, new_pc_o and exc_code_o.
  - flush_o stays high cycles t+1 … t+FLUSH_CYCLES, then drops.
  - new_pc_o returns to 0 when flush_o drops.
- Vector select, all sums mod 2^AW:
  - 0x01 interrupt → ebase_i+VEC_INT_OFF.
  - 0x08 syscall, 0x0a invalid instruction, 0x0c overflow, 0x0d trap → ebase_i+VEC_GEN_OFF.
  - 0x0e eret → cp0_epc_i, sampled at cycle t.
  - Any other nonzero code → ebase_i+VEC_GEN_OFF (no silent drop).
- excepttype_i≠0 while in FLUSH: ignored. The exception comes from a flushed instruction; no re-entry and no extension of flush.
- Stall, combinational from inputs:
  - k = highest set bit of stall_req_i.
  - stall_o = (1<<(k+1))-1, i.e. stages 0..k held.
  - stall_req_i=0 → stall_o=0.
  - Forced to 0 when excepttype_i≠0 or state=FLUSH (exception overrides stall).
  - Example, NSTAGE=6: request at EX (bit 3) → 6'b001111; at ID (bit 2) → 6'b000111.
- Watchdog:
  - Counter increments each cycle stall_o≠0 and clears to 0 in any cycle stall_o=0.
  - stall_timeout_o pulses exactly once, in the cycle after the STALL_TIMEOUT-th consecutive stalled cycle.
  - Counter then saturates, with no further pulses until the stall breaks.
  - Counter width = $clog2(STALL_TIMEOUT+1).
- Reset mid-FLUSH: next cycle state=IDLE, flush_o=0, new_pc_o=0, counters cleared.
- Simultaneous exception and stall request in IDLE: stall_o=0 that cycle; flush follows.

Decomposition:
- Shared package/defines:
  - exception code constants (EXC_INT=1, EXC_SYS=8, EXC_RI=0xa, EXC_OV=0xc, EXC_TR=0xd, EXC_ERET=0xe)
  - FSM state encoding (IDLE=0, FLUSH=1)
  - existing RstEnable/ZeroWord defines
- One natural sub-module, pipe_stall_mask: priority encoder from stall_req_i to a thermometer stall mask, parametrised by NSTAGE.
- FSM, vector select and watchdog stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with stall_req_i=6'b111111, excepttype_i=8 → stall_o=0 and flush_o=0 throughout. After release, stall_o=6'b111111.
- Stall mask: stall_req_i=6'b001000 → stall_o=6'b001111 same cycle. stall_req_i=6'b000100 → 6'b000111. Both bits 3 and 2 set → 6'b001111.
- Syscall: ebase_i=0x8000_0000, excepttype_i=8 for one cycle → next cycle flush_o=1, new_pc_o=0x8000_0040, exc_code_o=8. Then 0 after FLUSH_CYCLES.
- eret with FLUSH_CYCLES=3: cp0_epc_i=0x0000_1234, excepttype_i=0xe → flush_o high exactly 3 cycles with new_pc_o=0x1234. An interrupt code injected during cycle 2 of FLUSH is ignored; flush does not extend.
- Exception over stall: stall_req_i=6'b001000 and excepttype_i=1 same cycle, ebase_i=0 → stall_o=0 that cycle; next cycle new_pc_o=0x20.
- Watchdog with STALL_TIMEOUT=4:
  - Hold stall_req_i=1 for 10 cycles → stall_timeout_o high exactly once, in the 5th cycle.
  - Drop the request for 1 cycle and reassert → a fresh pulse after 4 more stalled cycles.

Source files
------------

// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared constants for the pipeline controller: exception codes, FSM encoding
// and the legacy reset/zero definitions used across the MIPS core.
package pipe_ctrl_gen_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Lowest stage held when a given stage requests a stall is always stage 0,
  // so the hold mask is a thermometer ending at the highest requester.
  function automatic int unsigned thermo_width(input int unsigned nstage);
    return (nstage < 1) ? 1 : nstage;
  endfunction

endpackage

// File: rtl/pipe_stall_mask.sv
// Priority encoder from per-stage stall requests to a thermometer hold mask:
// the highest requesting stage and every stage before it are held.
module pipe_stall_mask
  import pipe_ctrl_gen_pkg::*;
#(
  parameter int NSTAGE = 6
) (
  input  logic [NSTAGE-1:0] stall_req_i,
  output logic [NSTAGE-1:0] stall_mask_o
);

  // Stage gi is held if it or any later stage requests a stall.
  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_mask
    assign stall_mask_o[gi] = |stall_req_i[NSTAGE-1:gi];
  end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush/redirect controller: thermometer stall enables, a
// registered multi-cycle flush with redirect PC, and a stall watchdog.
module pipe_ctrl_gen
  import pipe_ctrl_gen_pkg::*;
#(
  parameter int          NSTAGE        = 6,
  parameter int          AW            = 32,
  parameter int          FLUSH_CYCLES  = 1,
  parameter int          STALL_TIMEOUT = 1024,
  parameter logic [31:0] VEC_INT_OFF   = 32'h20,
  parameter logic [31:0] VEC_GEN_OFF   = 32'h40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       excepttype_i,
  input  logic [AW-1:0]     cp0_epc_i,
  input  logic [AW-1:0]     ebase_i,
  input  logic [NSTAGE-1:0] stall_req_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [AW-1:0]     new_pc_o,
  output logic              busy_o,
  output logic              stall_timeout_o,
  output logic [4:0]        exc_code_o
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int WCW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

  state_e            state_q;
  logic [FCW-1:0]    fcnt_q;
  logic              flush_q;
  logic              busy_q;
  logic [AW-1:0]     new_pc_q;
  logic [AW-1:0]     new_pc_d;
  logic [4:0]        exc_code_q;
  logic [NSTAGE-1:0] stall_mask;
  logic              exc_pending;

  assign exc_pending = (excepttype_i != ZeroWord);

  pipe_stall_mask #(
    .NSTAGE(NSTAGE)
  ) u_stall_mask (
    .stall_req_i (stall_req_i),
    .stall_mask_o(stall_mask)
  );

  // An exception (incoming or being flushed) always overrides stalls so the
  // redirect is never held off by a stalled stage.
  assign stall_o = ((rst == RstEnable) || exc_pending || (state_q == ST_FLUSH))
                   ? '0 : stall_mask;

  always_comb begin
    new_pc_d = ebase_i + AW'(VEC_GEN_OFF);
    case (excepttype_i)
      EXC_INT:                         new_pc_d = ebase_i + AW'(VEC_INT_OFF);
      EXC_SYS, EXC_RI, EXC_OV, EXC_TR: new_pc_d = ebase_i + AW'(VEC_GEN_OFF);
      EXC_ERET:                        new_pc_d = cp0_epc_i;
      default:                         new_pc_d = ebase_i + AW'(VEC_GEN_OFF);
    endcase
  end

  // Exceptions arriving while in FLUSH belong to squashed instructions and
  // are dropped; they neither restart nor extend the flush.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= ST_IDLE;
      fcnt_q     <= '0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      new_pc_q   <= '0;
      exc_code_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exc_pending) begin
            state_q    <= ST_FLUSH;
            fcnt_q     <= FCW'(1);
            flush_q    <= 1'b1;
            busy_q     <= 1'b1;
            new_pc_q   <= new_pc_d;
            exc_code_q <= excepttype_i[4:0];
          end
        end
        ST_FLUSH: begin
          if (fcnt_q == FCW'(FLUSH_CYCLES)) begin
            state_q  <= ST_IDLE;
            fcnt_q   <= '0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            new_pc_q <= '0;
          end else begin
            fcnt_q <= fcnt_q + FCW'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          fcnt_q   <= '0;
          flush_q  <= 1'b0;
          busy_q   <= 1'b0;
          new_pc_q <= '0;
        end
      endcase
    end
  end

  assign flush_o    = flush_q;
  assign busy_o     = busy_q;
  assign new_pc_o   = new_pc_q;
  assign exc_code_o = exc_code_q;

  if (STALL_TIMEOUT > 0) begin : g_wdog
    logic [WCW-1:0] wcnt_q;
    logic           timeout_q;

    // The counter saturates at the limit so a long stall yields one pulse.
    always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
        wcnt_q    <= '0;
        timeout_q <= 1'b0;
      end else if (stall_o != '0) begin
        if (wcnt_q != WCW'(STALL_TIMEOUT)) begin
          wcnt_q <= wcnt_q + WCW'(1);
        end
        timeout_q <= (wcnt_q == WCW'(STALL_TIMEOUT - 1));
      end else begin
        wcnt_q    <= '0;
        timeout_q <= 1'b0;
      end
    end

    assign stall_timeout_o = timeout_q;
  end else begin : g_no_wdog
    assign stall_timeout_o = 1'b0;
  end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen: one instance with a 3-cycle flush and a
// 4-cycle watchdog, one with default parameters, both on shared inputs.
module tb_pipe_ctrl_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [31:0] ebase;
  logic [5:0]  stall_req;

  logic [5:0]  a_stall,   b_stall;
  logic        a_flush,   b_flush;
  logic [31:0] a_new_pc,  b_new_pc;
  logic        a_busy,    b_busy;
  logic        a_timeout, b_timeout;
  logic [4:0]  a_code,    b_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_gen #(
    .NSTAGE(6), .AW(32), .FLUSH_CYCLES(3), .STALL_TIMEOUT(4),
    .VEC_INT_OFF(32'h20), .VEC_GEN_OFF(32'h40)
  ) dut (
    .clk(clk), .rst(rst), .excepttype_i(excepttype), .cp0_epc_i(cp0_epc),
    .ebase_i(ebase), .stall_req_i(stall_req), .stall_o(a_stall),
    .flush_o(a_flush), .new_pc_o(a_new_pc), .busy_o(a_busy),
    .stall_timeout_o(a_timeout), .exc_code_o(a_code)
  );

  pipe_ctrl_gen dut1 (
    .clk(clk), .rst(rst), .excepttype_i(excepttype), .cp0_epc_i(cp0_epc),
    .ebase_i(ebase), .stall_req_i(stall_req), .stall_o(b_stall),
    .flush_o(b_flush), .new_pc_o(b_new_pc), .busy_o(b_busy),
    .stall_timeout_o(b_timeout), .exc_code_o(b_code)
  );

  task automatic test_reset();
    rst = 1'b1; stall_req = 6'b111111; excepttype = 32'h8;
    cp0_epc = 32'h0; ebase = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (a_stall !== 6'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 000000", a_stall); end
      n_cmp++; if (a_flush !== 1'b0 || b_flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %b/%b want 0/0", a_flush, b_flush); end
    end
    @(negedge clk); rst = 1'b0; excepttype = 32'h0; #1;
    n_cmp++; if (a_stall !== 6'b111111) begin n_bad++; $display("FAIL rst_release_stall: got %b want 111111", a_stall); end
    n_cmp++; if (a_busy !== 1'b0 || a_new_pc !== 32'h0 || a_code !== 5'h0 || a_timeout !== 1'b0)
      begin n_bad++; $display("FAIL rst_outputs: busy=%b pc=%h code=%h to=%b want all 0", a_busy, a_new_pc, a_code, a_timeout); end
    $display("reset: done");
  endtask

  task automatic test_stall_mask();
    @(negedge clk); stall_req = 6'b001000; #1;
    n_cmp++; if (a_stall !== 6'b001111) begin n_bad++; $display("FAIL mask_ex: got %b want 001111", a_stall); end
    @(negedge clk); stall_req = 6'b000100; #1;
    n_cmp++; if (a_stall !== 6'b000111) begin n_bad++; $display("FAIL mask_id: got %b want 000111", a_stall); end
    @(negedge clk); stall_req = 6'b001100; #1;
    n_cmp++; if (a_stall !== 6'b001111) begin n_bad++; $display("FAIL mask_ex_id: got %b want 001111", a_stall); end
    @(negedge clk); stall_req = 6'b100000; #1;
    n_cmp++; if (b_stall !== 6'b111111) begin n_bad++; $display("FAIL mask_wb: got %b want 111111", b_stall); end
    @(negedge clk); stall_req = 6'b000000; #1;
    n_cmp++; if (a_stall !== 6'b000000) begin n_bad++; $display("FAIL mask_none: got %b want 000000", a_stall); end
    $display("stall_mask: done");
  endtask

  task automatic test_syscall();
    @(negedge clk); ebase = 32'h8000_0000; excepttype = 32'h8;
    @(negedge clk); excepttype = 32'h0; #1;
    n_cmp++; if (b_flush !== 1'b1 || b_busy !== 1'b1) begin n_bad++; $display("FAIL sys_flush: got %b/%b want 1/1", b_flush, b_busy); end
    n_cmp++; if (b_new_pc !== 32'h8000_0040) begin n_bad++; $display("FAIL sys_pc: got %h want 80000040", b_new_pc); end
    n_cmp++; if (b_code !== 5'h08) begin n_bad++; $display("FAIL sys_code: got %h want 08", b_code); end
    @(negedge clk); #1;
    n_cmp++; if (b_flush !== 1'b0 || b_new_pc !== 32'h0 || b_busy !== 1'b0)
      begin n_bad++; $display("FAIL sys_drop: flush=%b pc=%h busy=%b want 0/0/0", b_flush, b_new_pc, b_busy); end
    n_cmp++; if (b_code !== 5'h08) begin n_bad++; $display("FAIL sys_code_hold: got %h want 08", b_code); end
    n_cmp++; if (a_flush !== 1'b1) begin n_bad++; $display("FAIL sys3_c2: got %b want 1", a_flush); end
    @(negedge clk); #1;
    n_cmp++; if (a_flush !== 1'b1) begin n_bad++; $display("FAIL sys3_c3: got %b want 1", a_flush); end
    @(negedge clk); #1;
    n_cmp++; if (a_flush !== 1'b0 || a_new_pc !== 32'h0) begin n_bad++; $display("FAIL sys3_drop: flush=%b pc=%h want 0/0", a_flush, a_new_pc); end
    $display("syscall: done");
  endtask

  task automatic test_eret();
    @(negedge clk); cp0_epc = 32'h0000_1234; excepttype = 32'he;
    @(negedge clk); excepttype = 32'h0; stall_req = 6'b001000; #1;
    n_cmp++; if (a_flush !== 1'b1 || a_new_pc !== 32'h1234) begin n_bad++; $display("FAIL eret_c1: flush=%b pc=%h want 1/00001234", a_flush, a_new_pc); end
    n_cmp++; if (a_code !== 5'h0e) begin n_bad++; $display("FAIL eret_code: got %h want 0e", a_code); end
    n_cmp++; if (a_stall !== 6'b0) begin n_bad++; $display("FAIL eret_stall_in_flush: got %b want 000000", a_stall); end
    @(negedge clk); excepttype = 32'h1; #1;
    n_cmp++; if (a_flush !== 1'b1) begin n_bad++; $display("FAIL eret_c2: got %b want 1", a_flush); end
    @(negedge clk); excepttype = 32'h0; #1;
    n_cmp++; if (a_flush !== 1'b1 || a_new_pc !== 32'h1234) begin n_bad++; $display("FAIL eret_c3: flush=%b pc=%h want 1/00001234", a_flush, a_new_pc); end
    n_cmp++; if (b_flush !== 1'b1 || b_new_pc !== 32'h8000_0020 || b_code !== 5'h01)
      begin n_bad++; $display("FAIL int_default: flush=%b pc=%h code=%h want 1/80000020/01", b_flush, b_new_pc, b_code); end
    @(negedge clk); #1;
    n_cmp++; if (a_flush !== 1'b0 || a_new_pc !== 32'h0 || a_busy !== 1'b0)
      begin n_bad++; $display("FAIL eret_drop: flush=%b pc=%h busy=%b want 0/0/0", a_flush, a_new_pc, a_busy); end
    n_cmp++; if (a_code !== 5'h0e) begin n_bad++; $display("FAIL eret_ignored_int: code got %h want 0e", a_code); end
    n_cmp++; if (a_stall !== 6'b001111) begin n_bad++; $display("FAIL eret_stall_resume: got %b want 001111", a_stall); end
    $display("eret: done");
  endtask

  task automatic test_exc_over_stall();
    @(negedge clk); ebase = 32'h0; stall_req = 6'b001000; excepttype = 32'h1; #1;
    n_cmp++; if (a_stall !== 6'b0 || b_stall !== 6'b0) begin n_bad++; $display("FAIL exc_over_stall: got %b/%b want 000000", a_stall, b_stall); end
    @(negedge clk); excepttype = 32'h0; stall_req = 6'b0; #1;
    n_cmp++; if (a_flush !== 1'b1 || a_new_pc !== 32'h20 || a_code !== 5'h01)
      begin n_bad++; $display("FAIL int_vec: flush=%b pc=%h code=%h want 1/00000020/01", a_flush, a_new_pc, a_code); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (a_flush !== 1'b0) begin n_bad++; $display("FAIL int_drop: got %b want 0", a_flush); end
    $display("exc_over_stall: done");
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) stall_req = 6'b000001;
      #1;
      n_cmp++; if (a_timeout !== (i == 4)) begin n_bad++; $display("FAIL wdog_hold[%0d]: got %b want %b", i, a_timeout, (i == 4)); end
    end
    for (int i = 10; i < 17; i++) begin
      @(negedge clk);
      if (i == 10) stall_req = 6'b000000;
      if (i == 11) stall_req = 6'b000001;
      #1;
      n_cmp++; if (a_timeout !== (i == 15)) begin n_bad++; $display("FAIL wdog_rearm[%0d]: got %b want %b", i, a_timeout, (i == 15)); end
    end
    n_cmp++; if (b_timeout !== 1'b0) begin n_bad++; $display("FAIL wdog_long_limit: got %b want 0", b_timeout); end
    @(negedge clk); stall_req = 6'b0;
    $display("watchdog: done");
  endtask

  task automatic test_back_to_back();
    @(negedge clk); ebase = 32'h0000_1000; excepttype = 32'ha;
    @(negedge clk); excepttype = 32'hc; #1;
    n_cmp++; if (b_flush !== 1'b1 || b_code !== 5'h0a || b_new_pc !== 32'h1040)
      begin n_bad++; $display("FAIL b2b_ri: flush=%b code=%h pc=%h want 1/0a/00001040", b_flush, b_code, b_new_pc); end
    @(negedge clk); excepttype = 32'hd; #1;
    n_cmp++; if (b_flush !== 1'b0 || b_code !== 5'h0a) begin n_bad++; $display("FAIL b2b_ov_ignored: flush=%b code=%h want 0/0a", b_flush, b_code); end
    @(negedge clk); excepttype = 32'h0; #1;
    n_cmp++; if (b_flush !== 1'b1 || b_code !== 5'h0d || b_new_pc !== 32'h1040)
      begin n_bad++; $display("FAIL b2b_tr: flush=%b code=%h pc=%h want 1/0d/00001040", b_flush, b_code, b_new_pc); end
    @(negedge clk); excepttype = 32'h55;
    @(negedge clk); excepttype = 32'h0; #1;
    n_cmp++; if (b_flush !== 1'b1 || b_code !== 5'h15 || b_new_pc !== 32'h1040)
      begin n_bad++; $display("FAIL b2b_unknown: flush=%b code=%h pc=%h want 1/15/00001040", b_flush, b_code, b_new_pc); end
    repeat (4) @(negedge clk);
    $display("back_to_back: done");
  endtask

  initial begin
    test_reset();
    test_stall_mask();
    test_syscall();
    test_eret();
    test_exc_over_stall();
    test_watchdog();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
